chroma_key_ctrl: RTL and testbench

- Control block for the chroma key mixer.
- Owns the mixer thresholds G_min / RG_max and updates them only on frame boundaries, so one frame never mixes with two threshold sets.
- Values come from one of two sources:
  - a host register write, or
  - an auto-calibration pass that samples a rectangular window of the camera stream (green screen region) and derives the thresholds from it.
- Sits beside the mixer: taps the camera pixel stream, drives the mixer threshold inputs, and drives a mix-enable gate.

---
 rtl/chroma_key_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_chroma_key_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_key_ctrl.sv
// Chroma key mixer control. Thresholds are double-buffered and change only on frame
// boundaries. They are loaded either by a host write or by auto-calibration over a pixel window.
module chroma_key_ctrl #(
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter int         WIN_X0     = 312,
    parameter int         WIN_Y0     = 232,
    parameter int         WIN_LOG2   = 4,
    parameter logic [7:0] G_MIN_RST  = 8'd10,
    parameter logic [7:0] RG_MAX_RST = 8'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    input  logic        i_pixel_valid,
    input  logic [15:0] rgb_data,
    input  logic        cfg_wr,
    input  logic [7:0]  cfg_G_min,
    input  logic [7:0]  cfg_RG_max,
    input  logic        cal_start,
    input  logic [3:0]  cal_offset,
    output logic [7:0]  G_min,
    output logic [7:0]  RG_max,
    output logic        mix_enable,
    output logic        cal_busy,
    output logic        cal_done
);

    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = $clog2(V_ACTIVE + 1);
    localparam int SW    = 4 + 2 * WIN_LOG2;
    localparam int WIN_N = 2 ** WIN_LOG2;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] WX_LO  = XW'(WIN_X0);
    localparam logic [XW-1:0] WX_HI  = XW'(WIN_X0 + WIN_N - 1);
    localparam logic [YW-1:0] WY_LO  = YW'(WIN_Y0);
    localparam logic [YW-1:0] WY_HI  = YW'(WIN_Y0 + WIN_N - 1);
    localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_SAMPLE,
        S_COMPUTE,
        S_COMMIT
    } state_t;

    state_t         r_state;
    state_t         w_nextState;

    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [SW-1:0]  r_sumG;
    logic [3:0]     r_maxR;
    logic [3:0]     r_maxB;
    logic [3:0]     r_shadowG;
    logic [3:0]     r_shadowRG;
    logic           r_pending;
    logic [7:0]     r_gMin;
    logic [7:0]     r_rgMax;
    logic           r_mixEnable;
    logic           r_calDone;

    logic [3:0]     w_pixR;
    logic [3:0]     w_pixG;
    logic [3:0]     w_pixB;
    logic           w_pixelAccept;
    logic           w_inWindow;
    logic           w_lastPixel;
    logic           w_cfgAccept;
    logic [3:0]     w_avgG;
    logic [3:0]     w_calG;
    logic [3:0]     w_maxRB;
    logic [4:0]     w_rgSum;
    logic [3:0]     w_calRG;
    logic           w_unused;

    assign w_pixR   = rgb_data[11:8];
    assign w_pixG   = rgb_data[7:4];
    assign w_pixB   = rgb_data[3:0];
    assign w_unused = ^{rgb_data[15:12], cfg_G_min[7:4], cfg_RG_max[7:4]};

    // A pixel on the same cycle as i_frame_start belongs to no frame and is dropped.
    assign w_pixelAccept = i_pixel_valid && !i_frame_start && (r_y < Y_END);
    assign w_inWindow    = w_pixelAccept && (r_x >= WX_LO) && (r_x <= WX_HI)
                           && (r_y >= WY_LO) && (r_y <= WY_HI);
    assign w_lastPixel   = w_inWindow && (r_x == WX_HI) && (r_y == WY_HI);
    assign w_cfgAccept   = cfg_wr && (r_state == S_IDLE);

    assign w_avgG  = r_sumG[SW-1 -: 4];
    assign w_calG  = (w_avgG > cal_offset) ? (w_avgG - cal_offset) : 4'd0;
    assign w_maxRB = (r_maxR > r_maxB) ? r_maxR : r_maxB;
    assign w_rgSum = {1'b0, w_maxRB} + {1'b0, cal_offset};
    assign w_calRG = w_rgSum[4] ? 4'hF : w_rgSum[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_frame_start) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pixelAccept) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:       if (cal_start)     w_nextState = S_WAIT_FRAME;
            S_WAIT_FRAME: if (i_frame_start) w_nextState = S_SAMPLE;
            S_SAMPLE:     if (w_lastPixel)   w_nextState = S_COMPUTE;
            S_COMPUTE:                       w_nextState = S_COMMIT;
            S_COMMIT:     if (i_frame_start) w_nextState = S_IDLE;
            default:                         w_nextState = S_IDLE;
        endcase
    end

    // Any frame start while sampling restarts the window in the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sumG <= '0;
            r_maxR <= '0;
            r_maxB <= '0;
        end else if (i_frame_start && (r_state == S_WAIT_FRAME || r_state == S_SAMPLE)) begin
            r_sumG <= '0;
            r_maxR <= '0;
            r_maxB <= '0;
        end else if (r_state == S_SAMPLE && w_inWindow) begin
            r_sumG <= r_sumG + SW'(w_pixG);
            if (w_pixR > r_maxR) r_maxR <= w_pixR;
            if (w_pixB > r_maxB) r_maxB <= w_pixB;
        end
    end

    // A host write that lands on a frame start bypasses the shadow and commits at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadowG   <= '0;
            r_shadowRG  <= '0;
            r_pending   <= 1'b0;
            r_gMin      <= G_MIN_RST;
            r_rgMax     <= RG_MAX_RST;
            r_mixEnable <= 1'b0;
        end else if (i_frame_start && w_cfgAccept) begin
            r_gMin      <= {4'b0, cfg_G_min[3:0]};
            r_rgMax     <= {4'b0, cfg_RG_max[3:0]};
            r_pending   <= 1'b0;
            r_mixEnable <= 1'b1;
        end else if (i_frame_start && r_pending) begin
            r_gMin      <= {4'b0, r_shadowG};
            r_rgMax     <= {4'b0, r_shadowRG};
            r_pending   <= 1'b0;
            r_mixEnable <= 1'b1;
        end else if (w_cfgAccept) begin
            r_shadowG   <= cfg_G_min[3:0];
            r_shadowRG  <= cfg_RG_max[3:0];
            r_pending   <= 1'b1;
        end else if (r_state == S_COMPUTE) begin
            r_shadowG   <= w_calG;
            r_shadowRG  <= w_calRG;
            r_pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_calDone <= 1'b0;
        end else begin
            r_calDone <= (r_state == S_COMMIT) && i_frame_start;
        end
    end

    assign G_min      = r_gMin;
    assign RG_max     = r_rgMax;
    assign mix_enable = r_mixEnable;
    assign cal_busy   = (r_state != S_IDLE);
    assign cal_done   = r_calDone;

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// Self-checking bench for chroma_key_ctrl on a reduced 20x16 frame with an 8x8 window.
// The bench covers the host-write table, directed calibration corners and randomized calibrations.
module tb_chroma_key_ctrl;

    localparam int H   = 20;
    localparam int V   = 16;
    localparam int WX0 = 6;
    localparam int WY0 = 4;
    localparam int WL  = 3;
    localparam int WN  = 1 << WL;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_frame_start;
    logic        i_pixel_valid;
    logic [15:0] rgb_data;
    logic        cfg_wr;
    logic [7:0]  cfg_G_min;
    logic [7:0]  cfg_RG_max;
    logic        cal_start;
    logic [3:0]  cal_offset;
    logic [7:0]  G_min;
    logic [7:0]  RG_max;
    logic        mix_enable;
    logic        cal_busy;
    logic        cal_done;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;

    logic [3:0] frameR [V][H];
    logic [3:0] frameG [V][H];
    logic [3:0] frameB [V][H];

    int curG  = 10;
    int curRG = 6;

    typedef struct {
        logic [7:0] wrG;
        logic [7:0] wrRG;
        bit         coincident;
        logic [7:0] expG;
        logic [7:0] expRG;
    } hostVec_t;

    hostVec_t vecs [4];

    chroma_key_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .WIN_X0(WX0), .WIN_Y0(WY0), .WIN_LOG2(WL),
        .G_MIN_RST(8'd10), .RG_MAX_RST(8'd6)
    ) dut (
        .clk(clk), .rst(rst),
        .i_frame_start(i_frame_start), .i_pixel_valid(i_pixel_valid), .rgb_data(rgb_data),
        .cfg_wr(cfg_wr), .cfg_G_min(cfg_G_min), .cfg_RG_max(cfg_RG_max),
        .cal_start(cal_start), .cal_offset(cal_offset),
        .G_min(G_min), .RG_max(RG_max), .mix_enable(mix_enable),
        .cal_busy(cal_busy), .cal_done(cal_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cal_done === 1'b1) doneCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int eg, input int erg, input logic em, input logic eb);
        checkOutput({tag, " G_min"}, G_min, eg);
        checkOutput({tag, " RG_max"}, RG_max, erg);
        checkOutput({tag, " mix_enable"}, mix_enable, em);
        checkOutput({tag, " cal_busy"}, cal_busy, eb);
    endtask

    // Lines of pixels with random idle gaps; junk drives all-15 pixels instead of the frame arrays.
    task automatic sendPixels(input int lines, input bit junk);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < H; x++) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_pixel_valid = 1'b0;
                    tick();
                end
                i_pixel_valid = 1'b1;
                rgb_data = junk ? 16'h0FFF : {4'b0, frameR[y][x], frameG[y][x], frameB[y][x]};
                tick();
            end
        end
        i_pixel_valid = 1'b0;
        rgb_data = 16'h0;
    endtask

    task automatic sendFrame(input int lines, input bit junk);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        sendPixels(lines, junk);
    endtask

    task automatic fillUniform(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                frameR[y][x] = r;
                frameG[y][x] = g;
                frameB[y][x] = b;
            end
    endtask

    task automatic fillRandom();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                frameR[y][x] = 4'($urandom_range(0, 15));
                frameG[y][x] = 4'($urandom_range(0, 15));
                frameB[y][x] = 4'($urandom_range(0, 15));
            end
    endtask

    // Reference: floor-average of window green minus offset, and peak red/blue plus offset, both clamped to 0..15.
    task automatic modelCal(input int offset, output int eg, output int erg);
        int sum;
        int peak;
        sum = 0;
        peak = 0;
        for (int y = WY0; y < WY0 + WN; y++)
            for (int x = WX0; x < WX0 + WN; x++) begin
                sum += int'(frameG[y][x]);
                if (int'(frameR[y][x]) > peak) peak = int'(frameR[y][x]);
                if (int'(frameB[y][x]) > peak) peak = int'(frameB[y][x]);
            end
        eg  = sum / (WN * WN) - offset;
        if (eg < 0) eg = 0;
        erg = peak + offset;
        if (erg > 15) erg = 15;
    endtask

    task automatic applyStimulus(input string tag, input int offset, input bit extra, input int abortLines);
        int eg;
        int erg;
        int doneBefore;
        doneBefore = doneCount;
        cal_offset = 4'(offset);
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        checkOutput({tag, " busy after start"}, cal_busy, 1);
        if (extra) begin
            cal_start  = 1'b1;
            cfg_wr     = 1'b1;
            cfg_G_min  = 8'd1;
            cfg_RG_max = 8'd1;
            tick();
            cal_start = 1'b0;
            cfg_wr    = 1'b0;
        end
        if (abortLines > 0) sendFrame(abortLines, 1'b1);
        sendFrame(V, 1'b0);
        modelCal(offset, eg, erg);
        checkAll({tag, " before commit"}, curG, curRG, 1'b1, 1'b1);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        checkAll({tag, " after commit"}, eg, erg, 1'b1, 1'b0);
        checkOutput({tag, " cal_done pulse"}, cal_done, 1);
        tick();
        checkOutput({tag, " cal_done low"}, cal_done, 0);
        checkOutput({tag, " single cal_done"}, doneCount - doneBefore, 1);
        curG  = eg;
        curRG = erg;
    endtask

    initial begin
        rst = 1'b1;
        i_frame_start = 1'b0;
        i_pixel_valid = 1'b0;
        rgb_data = 16'h0;
        cfg_wr = 1'b0;
        cfg_G_min = 8'h0;
        cfg_RG_max = 8'h0;
        cal_start = 1'b0;
        cal_offset = 4'h0;

        vecs[0] = '{wrG: 8'd9,  wrRG: 8'd5,  coincident: 1'b0, expG: 8'd9,  expRG: 8'd5};
        vecs[1] = '{wrG: 8'd3,  wrRG: 8'd12, coincident: 1'b1, expG: 8'd3,  expRG: 8'd12};
        vecs[2] = '{wrG: 8'd15, wrRG: 8'd0,  coincident: 1'b0, expG: 8'd15, expRG: 8'd0};
        vecs[3] = '{wrG: 8'd0,  wrRG: 8'd15, coincident: 1'b1, expG: 8'd0,  expRG: 8'd15};

        tick();
        tick();
        checkAll("reset", 10, 6, 1'b0, 1'b0);
        checkOutput("reset cal_done", cal_done, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            checkAll($sformatf("host%0d before", i), curG, curRG, i != 0, 1'b0);
            cfg_wr     = 1'b1;
            cfg_G_min  = vecs[i].wrG;
            cfg_RG_max = vecs[i].wrRG;
            if (!vecs[i].coincident) begin
                tick();
                cfg_wr = 1'b0;
                sendPixels(2, 1'b0);
                checkAll($sformatf("host%0d held", i), curG, curRG, i != 0, 1'b0);
                i_frame_start = 1'b1;
                tick();
            end else begin
                i_frame_start = 1'b1;
                tick();
                cfg_wr = 1'b0;
            end
            i_frame_start = 1'b0;
            checkAll($sformatf("host%0d commit", i), vecs[i].expG, vecs[i].expRG, 1'b1, 1'b0);
            curG  = vecs[i].expG;
            curRG = vecs[i].expRG;
            tick();
        end

        fillUniform(4'd3, 4'd12, 4'd5);
        applyStimulus("uniform", 2, 1'b1, 0);
        checkAll("uniform expected", 10, 7, 1'b1, 1'b0);
        sendFrame(1, 1'b0);
        checkAll("ignored cfg_wr", 10, 7, 1'b1, 1'b0);

        fillUniform(4'd14, 4'd1, 4'd0);
        applyStimulus("saturate", 4, 1'b0, 0);
        checkAll("saturate expected", 0, 15, 1'b1, 1'b0);

        fillUniform(4'd2, 4'd8, 4'd4);
        applyStimulus("short frame", 3, 1'b0, WY0 + 6);
        checkAll("short frame expected", 5, 7, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            fillRandom();
            applyStimulus($sformatf("random%0d", i), int'($urandom_range(0, 15)), 1'b0, 0);
        end

        // Asynchronous reset while sampling, away from any clock edge.
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        sendFrame(WY0 + 3, 1'b0);
        checkOutput("pre-reset busy", cal_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkAll("async reset", 10, 6, 1'b0, 1'b0);
        checkOutput("async reset cal_done", cal_done, 0);
        tick();
        rst = 1'b0;
        tick();
        sendFrame(1, 1'b0);
        checkAll("post-reset frame", 10, 6, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
